// File: rtl/data_sync_pkg.sv
// Shared definitions for the multi-channel enable-qualified synchroniser.
// Optional build feature: DATA_SYNC_OVR_CNT_EN (per-channel overrun counters).
package data_sync_pkg;

    localparam int EN_MODE_LEVEL  = 0;
    localparam int EN_MODE_TOGGLE = 1;
    localparam int OVR_CNT_W      = 8;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_t;

    // Saturating increment for the dropped-capture counter
    function automatic logic [OVR_CNT_W-1:0] sat_inc(input logic [OVR_CNT_W-1:0] v);
        logic [OVR_CNT_W-1:0] r;
        if (v == {OVR_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(OVR_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sync_ch.sv
// One synchroniser channel: enable sync chain, edge qualification, holding
// register with valid/ready, acknowledge toggle and sticky overrun.
// Optional build feature: DATA_SYNC_OVR_CNT_EN adds a saturating drop counter.
module data_sync_ch
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 3,
    parameter int EN_MODE    = 0
) (
    input  logic                 clck,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 bus_en,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 sync_ready,
    input  logic                 overrun_clr,
    output logic [BUS_WIDTH-1:0] sync_bus,
    output logic                 sync_valid,
    output logic                 en_pulse,
    output logic                 ack_tgl,
`ifdef DATA_SYNC_OVR_CNT_EN
    output logic [OVR_CNT_W-1:0] ovr_cnt,
`endif
    output logic                 overrun
);

    logic [NUM_STAGES-1:0] sync_r;
    logic                  hist_r;
    logic                  s_last_s;
    logic                  edge_s;
    logic                  load_s;
    logic                  drop_s;
    logic [BUS_WIDTH-1:0]  data_r;
    logic                  valid_r;
    logic                  cap_r;
    logic                  pulse_r;
    logic                  ack_r;
    logic                  ovr_r;

    assign s_last_s = sync_r[NUM_STAGES-1];

    // Enable synchroniser chain and edge-history flop
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            sync_r <= {NUM_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[NUM_STAGES-2:0], bus_en};
            hist_r <= s_last_s;
        end
    end

    // Qualify the edge (masked until RUN) and decide load versus drop
    always_comb begin
        edge_s = 1'b0;
        load_s = 1'b0;
        drop_s = 1'b0;
        if (!run) begin
            edge_s = 1'b0;
        end else if (EN_MODE == EN_MODE_TOGGLE) begin
            edge_s = s_last_s ^ hist_r;
        end else begin
            edge_s = s_last_s & ~hist_r;
        end
        load_s = edge_s & (~valid_r | sync_ready);
        drop_s = edge_s & valid_r & ~sync_ready;
    end

    // Holding register, valid flag, acknowledge toggle and strobe pipeline
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            data_r  <= {BUS_WIDTH{1'b0}};
            valid_r <= 1'b0;
            ack_r   <= 1'b0;
            cap_r   <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            cap_r   <= load_s;
            pulse_r <= cap_r;
            if (load_s) begin
                data_r  <= unsync_bus;
                valid_r <= 1'b1;
                ack_r   <= ~ack_r;
            end else if (valid_r && sync_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    // Sticky overrun: a set in the same cycle as a clear takes priority
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            ovr_r <= 1'b0;
        end else if (drop_s) begin
            ovr_r <= 1'b1;
        end else if (overrun_clr) begin
            ovr_r <= 1'b0;
        end else begin
            ovr_r <= ovr_r;
        end
    end

`ifdef DATA_SYNC_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] cnt_r;

    // Dropped-capture counter; a drop coinciding with a clear restarts at one
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            cnt_r <= {OVR_CNT_W{1'b0}};
        end else if (drop_s && overrun_clr) begin
            cnt_r <= {{(OVR_CNT_W-1){1'b0}}, 1'b1};
        end else if (drop_s) begin
            cnt_r <= sat_inc(cnt_r);
        end else if (overrun_clr) begin
            cnt_r <= {OVR_CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign ovr_cnt = cnt_r;
`endif

    assign sync_bus   = data_r;
    assign sync_valid = valid_r;
    assign en_pulse   = pulse_r;
    assign ack_tgl    = ack_r;
    assign overrun    = ovr_r;

endmodule

// File: rtl/data_sync_mc.sv
// Multi-channel enable-qualified synchroniser top: shared init FSM that masks
// edge detection until the sync chains have settled, plus NUM_CH channels.
// Optional build feature: DATA_SYNC_OVR_CNT_EN adds the ovr_cnt output.
module data_sync_mc
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 3,
    parameter int NUM_CH     = 2,
    parameter int EN_MODE    = 0
) (
    input  logic                          clck,
    input  logic                          rst,
    input  logic [NUM_CH*BUS_WIDTH-1:0]   unsync_bus,
    input  logic [NUM_CH-1:0]             bus_en,
    input  logic [NUM_CH-1:0]             sync_ready,
    input  logic [NUM_CH-1:0]             overrun_clr,
    output logic [NUM_CH*BUS_WIDTH-1:0]   sync_bus,
    output logic [NUM_CH-1:0]             sync_valid,
    output logic [NUM_CH-1:0]             en_pulse,
    output logic [NUM_CH-1:0]             ack_tgl,
`ifdef DATA_SYNC_OVR_CNT_EN
    output logic [NUM_CH*OVR_CNT_W-1:0]   ovr_cnt,
`endif
    output logic [NUM_CH-1:0]             overrun
);

    localparam int CNT_W = $clog2(NUM_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_STAGES);

    init_state_t      state_r;
    init_state_t      state_nx;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nx;
    logic             run_s;

    // Init FSM state and settle counter
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            state_r <= INIT;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Init FSM next state: stay in INIT for NUM_STAGES+1 clocks, then RUN for good
    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        case (state_r)
            INIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx = RUN;
                    cnt_nx   = {CNT_W{1'b0}};
                end else begin
                    state_nx = INIT;
                    cnt_nx   = cnt_r + CNT_W'(1);
                end
            end
            RUN: begin
                state_nx = RUN;
                cnt_nx   = {CNT_W{1'b0}};
            end
            default: begin
                state_nx = INIT;
                cnt_nx   = {CNT_W{1'b0}};
            end
        endcase
    end

    assign run_s = (state_r == RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        data_sync_ch #(
            .BUS_WIDTH  (BUS_WIDTH),
            .NUM_STAGES (NUM_STAGES),
            .EN_MODE    (EN_MODE)
        ) u_ch (
            .clck        (clck),
            .rst         (rst),
            .run         (run_s),
            .bus_en      (bus_en[g]),
            .unsync_bus  (unsync_bus[g*BUS_WIDTH +: BUS_WIDTH]),
            .sync_ready  (sync_ready[g]),
            .overrun_clr (overrun_clr[g]),
            .sync_bus    (sync_bus[g*BUS_WIDTH +: BUS_WIDTH]),
            .sync_valid  (sync_valid[g]),
            .en_pulse    (en_pulse[g]),
            .ack_tgl     (ack_tgl[g]),
`ifdef DATA_SYNC_OVR_CNT_EN
            .ovr_cnt     (ovr_cnt[g*OVR_CNT_W +: OVR_CNT_W]),
`endif
            .overrun     (overrun[g])
        );
    end

endmodule
